// File: rtl/obi_ext_slave_cut_pkg.sv
// Shared types and sizing constants for the registered OBI cut toward the external slave.
// The request payload is everything but req: {we, be, addr, wdata}.
package obi_ext_slave_cut_pkg;

    localparam int EXT_CUT_REQ_DEPTH       = 2;
    localparam int EXT_CUT_MAX_OUTSTANDING = 4;
    localparam int OBI_PAYLOAD_W           = 1 + 4 + 32 + 32;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    typedef logic [OBI_PAYLOAD_W-1:0] obi_payload_t;

    function automatic obi_payload_t pack_payload(input obi_req_t r);
        return {r.we, r.be, r.addr, r.wdata};
    endfunction

endpackage

// File: rtl/obi_cut_req_fifo.sv
// Synchronous request-payload FIFO for the OBI cut; no fall-through, so a push into
// an empty FIFO shows up on data_o one cycle later.
module obi_cut_req_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 69
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; empty gates every use of data_o.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/obi_ext_slave_cut.sv
// Registered OBI slice toward the external slave: buffers requests, registers responses,
// bounds in-flight transactions and flags responses that arrive with nothing outstanding.
module obi_ext_slave_cut
    import obi_ext_slave_cut_pkg::*;
#(
    parameter int REQ_DEPTH       = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  obi_req_t  slv_req_i,
    output obi_resp_t slv_resp_o,
    output obi_req_t  mst_req_o,
    input  obi_resp_t mst_resp_i,
    output logic      err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0]  up_cnt;
    logic [CNT_W-1:0]  dn_cnt;
    logic              rvalid_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              fifo_full;
    logic              fifo_empty;
    obi_payload_t      fifo_head;

    logic              up_hs;
    logic              dn_hs;
    logic              rsp_ok;
    logic              rsp_spurious;

    // Grant looks only at registered state and the upstream req, never at mst_resp_i.
    assign up_hs        = slv_req_i.req & ~fifo_full & (up_cnt < CNT_W'(MAX_OUTSTANDING));
    assign dn_hs        = ~fifo_empty & mst_resp_i.gnt;
    assign rsp_ok       = mst_resp_i.rvalid & (dn_cnt != '0);
    assign rsp_spurious = mst_resp_i.rvalid & (dn_cnt == '0);

    obi_cut_req_fifo #(
        .DEPTH (REQ_DEPTH),
        .WIDTH (OBI_PAYLOAD_W)
    ) u_req_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push   (up_hs),
        .pop    (dn_hs),
        .data_i (pack_payload(slv_req_i)),
        .data_o (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            up_cnt   <= '0;
            dn_cnt   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (up_hs && !rvalid_q) begin
                up_cnt <= up_cnt + CNT_W'(1);
            end else if (!up_hs && rvalid_q) begin
                up_cnt <= up_cnt - CNT_W'(1);
            end

            if (dn_hs && !rsp_ok) begin
                dn_cnt <= dn_cnt + CNT_W'(1);
            end else if (!dn_hs && rsp_ok) begin
                dn_cnt <= dn_cnt - CNT_W'(1);
            end

            rvalid_q <= rsp_ok;
            if (rsp_ok) begin
                rdata_q <= mst_resp_i.rdata;
            end

            // Sticky until reset: a late response from before a reset also lands here.
            if (rsp_spurious) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        slv_resp_o        = '0;
        slv_resp_o.gnt    = up_hs;
        slv_resp_o.rvalid = rvalid_q;
        slv_resp_o.rdata  = rdata_q;

        mst_req_o       = '0;
        mst_req_o.req   = ~fifo_empty;
        mst_req_o.we    = fifo_head[68];
        mst_req_o.be    = fifo_head[67:64];
        mst_req_o.addr  = fifo_head[63:32];
        mst_req_o.wdata = fifo_head[31:0];
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_obi_ext_slave_cut.sv
// Self-checking bench for obi_ext_slave_cut: directed scenarios plus a randomized run,
// all compared cycle by cycle against a queue-based transaction model.
module tb_obi_ext_slave_cut;
    import obi_ext_slave_cut_pkg::*;

    localparam int DEPTH = EXT_CUT_REQ_DEPTH;
    localparam int MAXO  = EXT_CUT_MAX_OUTSTANDING;

    logic      clk_i = 1'b0;
    logic      rst_i = 1'b1;
    obi_req_t  slv_req_i = '0;
    obi_resp_t slv_resp_o;
    obi_req_t  mst_req_o;
    obi_resp_t mst_resp_i = '0;
    logic      err_o;

    always #5 clk_i = ~clk_i;

    obi_ext_slave_cut #(
        .REQ_DEPTH       (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .slv_req_i  (slv_req_i),
        .slv_resp_o (slv_resp_o),
        .mst_req_o  (mst_req_o),
        .mst_resp_i (mst_resp_i),
        .err_o      (err_o)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Transaction model: buffered requests, accepted-but-unanswered count,
    // downstream-granted-but-unanswered count, and the pending upstream response.
    obi_payload_t m_fifo[$];
    int           m_out = 0;
    int           m_dn  = 0;
    logic         m_rv  = 1'b0;
    logic [31:0]  m_rdata = '0;
    logic         m_err = 1'b0;

    logic         exp_gnt, exp_mreq;
    obi_payload_t exp_mpay;
    logic         obs_gnt, obs_mreq, obs_rv, obs_err;
    obi_payload_t obs_mpay;
    logic [31:0]  obs_rdata;
    logic [104:0] obs_all, exp_all;
    logic         last_dn_hs = 1'b0;
    int           rv_seen = 0;

    function automatic obi_payload_t rand_pay();
        return {1'($urandom), 4'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    task automatic do_reset();
        @(negedge clk_i);
        rst_i      = 1'b1;
        slv_req_i  = '0;
        mst_resp_i = '0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        m_fifo.delete();
        m_out = 0; m_dn = 0; m_rv = 1'b0; m_rdata = '0; m_err = 1'b0;
        last_dn_hs = 1'b0;
    endtask

    task automatic apply(input logic req, input obi_payload_t pay, input logic mgnt,
                         input logic mrv, input logic [31:0] mrdata);
        @(negedge clk_i);
        slv_req_i  = '{req: req, we: pay[68], be: pay[67:64], addr: pay[63:32], wdata: pay[31:0]};
        mst_resp_i = '{gnt: mgnt, rvalid: mrv, rdata: mrdata};
        #1;
        exp_gnt  = req && (m_fifo.size() < DEPTH) && (m_out < MAXO);
        exp_mreq = (m_fifo.size() > 0);
        exp_mpay = exp_mreq ? m_fifo[0] : '0;
        obs_gnt   = slv_resp_o.gnt;
        obs_mreq  = mst_req_o.req;
        obs_mpay  = exp_mreq ? {mst_req_o.we, mst_req_o.be, mst_req_o.addr, mst_req_o.wdata} : '0;
        obs_rv    = slv_resp_o.rvalid;
        obs_rdata = slv_resp_o.rdata;
        obs_err   = err_o;
        obs_all   = {obs_gnt, obs_mreq, obs_mpay, obs_rv, obs_rdata, obs_err};
        exp_all   = {exp_gnt, exp_mreq, exp_mpay, m_rv, m_rdata, m_err};
        if (obs_rv) rv_seen++;
        last_dn_hs = exp_mreq && mgnt;
        @(posedge clk_i);
        if (m_rv) m_out--;
        if (mrv) begin
            if (m_dn > 0) begin
                m_rv = 1'b1; m_rdata = mrdata; m_dn--;
            end else begin
                m_rv = 1'b0; m_err = 1'b1;
            end
        end else begin
            m_rv = 1'b0;
        end
        if (last_dn_hs) begin
            void'(m_fifo.pop_front());
            m_dn++;
        end
        if (exp_gnt) begin
            m_fifo.push_back(pay);
            m_out++;
        end
    endtask

    task automatic drain(output int bad, output bit timeout);
        bad = 0;
        for (int c = 0; c < 60 && (m_fifo.size() > 0 || m_out > 0); c++) begin
            apply(1'b0, '0, 1'b1, (m_dn > 0), $urandom);
            if (obs_all !== exp_all) bad++;
        end
        timeout = (m_fifo.size() > 0 || m_out > 0);
    endtask

    task automatic test_reset();
        do_reset();
        apply(1'b0, '0, 1'b0, 1'b0, '0);
        n_checks++;
        if ({obs_gnt, obs_mreq, obs_rv, obs_rdata, obs_err} !== '0) begin
            n_errs++;
            $display("FAIL reset_outputs got=%h required=0", {obs_gnt, obs_mreq, obs_rv, obs_rdata, obs_err});
        end
        apply(1'b1, rand_pay(), 1'b0, 1'b0, '0);
        n_checks++;
        if (obs_gnt !== 1'b1) begin
            n_errs++;
            $display("FAIL reset_first_gnt got=%b required=1", obs_gnt);
        end
    endtask

    task automatic test_single_read();
        obi_payload_t p;
        p = {1'b0, 4'hF, 32'h2000_0010, 32'h0};
        do_reset();
        apply(1'b1, p, 1'b1, 1'b0, '0);
        n_checks++;
        if ({obs_gnt, obs_mreq} !== 2'b10) begin
            n_errs++;
            $display("FAIL single_accept gnt,mreq got=%b required=10", {obs_gnt, obs_mreq});
        end
        apply(1'b0, '0, 1'b1, 1'b0, '0);
        n_checks++;
        if (obs_mreq !== 1'b1 || obs_mpay !== p) begin
            n_errs++;
            $display("FAIL single_dn_req got=%b/%h required=1/%h", obs_mreq, obs_mpay, p);
        end
        apply(1'b0, '0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        n_checks++;
        if (obs_rv !== 1'b0) begin
            n_errs++;
            $display("FAIL single_rv_early got=%b required=0", obs_rv);
        end
        apply(1'b0, '0, 1'b1, 1'b0, '0);
        n_checks++;
        if ({obs_rv, obs_rdata, obs_err} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
            n_errs++;
            $display("FAIL single_resp rv,rdata,err got=%b,%h,%b required=1,deadbeef,0", obs_rv, obs_rdata, obs_err);
        end
    endtask

    task automatic test_back_to_back();
        int bad, grants;
        bit to;
        do_reset();
        rv_seen = 0;
        grants  = 0;
        bad     = 0;
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, {1'b1, 4'($urandom), 32'($urandom), 32'($urandom)}, 1'b1, last_dn_hs, $urandom);
            if (obs_gnt === 1'b1) grants++;
            n_checks++;
            if (obs_all !== exp_all) begin
                n_errs++;
                $display("FAIL b2b cyc=%0d got=%h required=%h", i, obs_all, exp_all);
            end
        end
        n_checks++;
        if (grants !== 16) begin
            n_errs++;
            $display("FAIL b2b_grants got=%0d required=16", grants);
        end
        drain(bad, to);
        n_checks++;
        if (bad !== 0 || to) begin
            n_errs++;
            $display("FAIL b2b_drain bad_cycles=%0d timeout=%0b required 0/0", bad, to);
        end
        n_checks++;
        if (rv_seen !== 16) begin
            n_errs++;
            $display("FAIL b2b_rvalids got=%0d required=16", rv_seen);
        end
    endtask

    task automatic test_outstanding_limit();
        int bad, grants;
        bit to;
        do_reset();
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, rand_pay(), 1'b1, 1'b0, '0);
            if (obs_gnt === 1'b1) grants++;
            n_checks++;
            if (obs_all !== exp_all) begin
                n_errs++;
                $display("FAIL limit_fill cyc=%0d got=%h required=%h", i, obs_all, exp_all);
            end
        end
        n_checks++;
        if (grants !== MAXO) begin
            n_errs++;
            $display("FAIL limit_grants got=%0d required=%0d", grants, MAXO);
        end
        grants = 0;
        for (int i = 0; i < 7; i++) begin
            apply(1'b1, rand_pay(), 1'b1, (i == 0), 32'h5A5A_0000);
            if (obs_gnt === 1'b1) grants++;
            n_checks++;
            if (obs_gnt !== (i == 2)) begin
                n_errs++;
                $display("FAIL limit_release cyc=%0d gnt got=%b required=%b", i, obs_gnt, (i == 2));
            end
        end
        n_checks++;
        if (grants !== 1) begin
            n_errs++;
            $display("FAIL limit_release_count got=%0d required=1", grants);
        end
        drain(bad, to);
        n_checks++;
        if (bad !== 0 || to) begin
            n_errs++;
            $display("FAIL limit_drain bad_cycles=%0d timeout=%0b required 0/0", bad, to);
        end
    endtask

    task automatic test_backpressure();
        obi_payload_t p0, p1, pay, head;
        int bad, grants;
        bit to;
        do_reset();
        p0 = rand_pay();
        p1 = rand_pay();
        pay = p0;
        grants = 0;
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, pay, 1'b0, 1'b0, '0);
            if (obs_gnt === 1'b1) begin
                grants++;
                pay = (grants == 1) ? p1 : rand_pay();
            end
            if (i == 1) head = obs_mpay;
            n_checks++;
            if (obs_all !== exp_all || (i > 1 && obs_mpay !== head)) begin
                n_errs++;
                $display("FAIL bp_hold cyc=%0d got=%h required=%h", i, obs_all, exp_all);
            end
        end
        n_checks++;
        if (grants !== 2) begin
            n_errs++;
            $display("FAIL bp_grants got=%0d required=2", grants);
        end
        apply(1'b0, '0, 1'b1, 1'b0, '0);
        n_checks++;
        if (obs_mpay !== p0) begin
            n_errs++;
            $display("FAIL bp_first got=%h required=%h", obs_mpay, p0);
        end
        apply(1'b0, '0, 1'b1, 1'b0, '0);
        n_checks++;
        if (obs_mpay !== p1 || obs_mreq !== 1'b1) begin
            n_errs++;
            $display("FAIL bp_second got=%h required=%h", obs_mpay, p1);
        end
        drain(bad, to);
        n_checks++;
        if (bad !== 0 || to) begin
            n_errs++;
            $display("FAIL bp_drain bad_cycles=%0d timeout=%0b required 0/0", bad, to);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        apply(1'b0, '0, 1'b0, 1'b1, 32'h0000_1234);
        apply(1'b0, '0, 1'b0, 1'b0, '0);
        n_checks++;
        if ({obs_rv, obs_err} !== 2'b01) begin
            n_errs++;
            $display("FAIL spurious rv,err got=%b required=01", {obs_rv, obs_err});
        end
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, '0, 1'b0, 1'b0, '0);
            n_checks++;
            if (obs_err !== 1'b1) begin
                n_errs++;
                $display("FAIL spurious_sticky cyc=%0d got=%b required=1", i, obs_err);
            end
        end
        do_reset();
        apply(1'b0, '0, 1'b0, 1'b0, '0);
        n_checks++;
        if (obs_err !== 1'b0) begin
            n_errs++;
            $display("FAIL spurious_clear got=%b required=0", obs_err);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        apply(1'b1, rand_pay(), 1'b0, 1'b0, '0);
        apply(1'b1, rand_pay(), 1'b1, 1'b0, '0);
        apply(1'b1, rand_pay(), 1'b0, 1'b0, '0);
        n_checks++;
        if (obs_all !== exp_all) begin
            n_errs++;
            $display("FAIL midflight_pre got=%h required=%h", obs_all, exp_all);
        end
        do_reset();
        apply(1'b0, '0, 1'b0, 1'b0, '0);
        n_checks++;
        if ({obs_gnt, obs_mreq, obs_rv, obs_rdata, obs_err} !== '0) begin
            n_errs++;
            $display("FAIL midflight_reset got=%h required=0", {obs_gnt, obs_mreq, obs_rv, obs_rdata, obs_err});
        end
        apply(1'b0, '0, 1'b0, 1'b1, 32'hCAFE_F00D);
        apply(1'b0, '0, 1'b0, 1'b0, '0);
        n_checks++;
        if ({obs_rv, obs_err, obs_mreq} !== 3'b010) begin
            n_errs++;
            $display("FAIL midflight_late rv,err,mreq got=%b required=010", {obs_rv, obs_err, obs_mreq});
        end
    endtask

    task automatic test_random();
        obi_payload_t pay;
        logic req, mgnt, mrv, last_gnt;
        int bad;
        bit to;
        do_reset();
        req = 1'b0;
        last_gnt = 1'b0;
        pay = '0;
        for (int c = 0; c < 300; c++) begin
            if (!req || last_gnt) begin
                req = ($urandom_range(0, 3) != 0);
                pay = rand_pay();
            end
            mgnt = ($urandom_range(0, 2) != 0);
            mrv  = (m_dn > 0) && ($urandom_range(0, 1) == 1);
            apply(req, pay, mgnt, mrv, $urandom);
            last_gnt = exp_gnt;
            n_checks++;
            if (obs_all !== exp_all) begin
                n_errs++;
                $display("FAIL random cyc=%0d got=%h required=%h", c, obs_all, exp_all);
            end
        end
        drain(bad, to);
        n_checks++;
        if (bad !== 0 || to) begin
            n_errs++;
            $display("FAIL random_drain bad_cycles=%0d timeout=%0b required 0/0", bad, to);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_outstanding_limit();
        test_backpressure();
        test_spurious();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
